// File: rtl/ea_seq.sv
//==============================================================================
// Module     : ea_seq
// Description: Effective-address sequencer for 6502/65816-style addressing
//              modes, with two-byte pointer fetches for indirect modes.
//              Optional macro EA_SEQ_PAGE_PENALTY_EN adds a one-cycle penalty
//              state when an indexed address crosses a page.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module ea_seq #(
    parameter int          AW         = 16,
    parameter int          ZP_WRAP    = 1,
    parameter logic [7:0]  STACK_PAGE = 8'h01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [3:0]    mode,
    input  logic [15:0]   operand,
    input  logic [7:0]    x,
    input  logic [7:0]    y,
    input  logic [7:0]    sp,
    input  logic [7:0]    bank,
    output logic          busy,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_dat,
    output logic [AW-1:0] ea,
    output logic          ea_valid,
    output logic          page_cross,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_RDLO = 3'd2,
        S_RDHI = 3'd3,
        S_DONE = 3'd5
`ifdef EA_SEQ_PAGE_PENALTY_EN
        , S_PEN = 3'd4
`endif
    } state_t;

    state_t      r_state;
    logic [3:0]  r_mode;
    logic [15:0] r_operand;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_sp;
    logic [7:0]  r_bank;
    logic [7:0]  r_lo;
    logic [15:0] r_ptr;
    logic        r_illegal;
`ifdef EA_SEQ_PAGE_PENALTY_EN
    logic [AW-1:0] r_pend_ea;
`endif

    logic [AW-1:0] w_bank_hi;
    logic [8:0]    w_zpx_sum;
    logic [8:0]    w_zpy_sum;
    logic [7:0]    w_sp_sum;
    logic [15:0]   w_absx;
    logic [15:0]   w_absy;
    logic [15:0]   w_dir_ea16;
    logic          w_dir_use_bank;
    logic          w_dir_cross;
    logic [15:0]   w_ptr;
    logic          w_indirect;
    logic [15:0]   w_ptr_next;
    logic [7:0]    w_ind_idx;
    logic [8:0]    w_ind_lo_sum;
    logic [15:0]   w_ind_ptr;
    logic [AW-1:0] w_dir_ea;
    logic [AW-1:0] w_ind_ea;
    logic          w_finish;
    logic [AW-1:0] w_fin_ea;
    logic          w_fin_cross;
    logic          w_unused_bank;

    // Bank only contributes address bits above bit 15; none exist when AW is 16.
    generate
        if (AW > 16) begin : g_bank
            assign w_bank_hi = {r_bank[AW-17:0], 16'h0000};
        end else begin : g_no_bank
            assign w_bank_hi = '0;
        end
    endgenerate

    assign w_unused_bank = &{1'b0, r_bank};

    assign w_zpx_sum = {1'b0, r_operand[7:0]} + {1'b0, r_x};
    assign w_zpy_sum = {1'b0, r_operand[7:0]} + {1'b0, r_y};
    assign w_sp_sum  = r_sp + r_operand[7:0];
    assign w_absx    = r_operand + {8'h00, r_x};
    assign w_absy    = r_operand + {8'h00, r_y};

    always_comb begin
        w_dir_ea16     = 16'h0000;
        w_dir_use_bank = 1'b0;
        w_dir_cross    = 1'b0;
        w_ptr          = 16'h0000;
        w_indirect     = 1'b0;
        case (r_mode)
            4'd0: w_dir_ea16 = {8'h00, r_operand[7:0]};
            4'd1: w_dir_ea16 = {8'h00, w_zpx_sum[7:0]};
            4'd2: w_dir_ea16 = {8'h00, w_zpy_sum[7:0]};
            4'd3: begin
                w_dir_ea16     = r_operand;
                w_dir_use_bank = 1'b1;
            end
            4'd4: begin
                w_dir_ea16     = w_absx;
                w_dir_use_bank = 1'b1;
                w_dir_cross    = w_zpx_sum[8];
            end
            4'd5: begin
                w_dir_ea16     = w_absy;
                w_dir_use_bank = 1'b1;
                w_dir_cross    = w_zpy_sum[8];
            end
            4'd9: w_dir_ea16 = {STACK_PAGE, w_sp_sum};
            4'd6: begin
                w_indirect = 1'b1;
                w_ptr      = {8'h00, w_zpx_sum[7:0]};
            end
            4'd7, 4'd8: begin
                w_indirect = 1'b1;
                w_ptr      = {8'h00, r_operand[7:0]};
            end
            4'd10: begin
                w_indirect = 1'b1;
                w_ptr      = {STACK_PAGE, w_sp_sum};
            end
            default: ;
        endcase
    end

    assign w_ptr_next = (ZP_WRAP != 0) ? {r_ptr[15:8], r_ptr[7:0] + 8'd1}
                                       : r_ptr + 16'd1;

    // Post-index by y only for (zp),y and (d,sp),y; the high byte arrives on mem_dat.
    assign w_ind_idx    = ((r_mode == 4'd7) || (r_mode == 4'd10)) ? r_y : 8'h00;
    assign w_ind_lo_sum = {1'b0, r_lo} + {1'b0, w_ind_idx};
    assign w_ind_ptr    = {mem_dat, r_lo} + {8'h00, w_ind_idx};

    assign w_dir_ea = (w_dir_use_bank ? w_bank_hi : '0) | AW'(w_dir_ea16);
    assign w_ind_ea = w_bank_hi | AW'(w_ind_ptr);

    assign w_finish    = ((r_state == S_CALC) && !r_illegal && !w_indirect) ||
                         ((r_state == S_RDHI) && mem_ack);
    assign w_fin_ea    = (r_state == S_RDHI) ? w_ind_ea : w_dir_ea;
    assign w_fin_cross = (r_state == S_RDHI) ? w_ind_lo_sum[8] : w_dir_cross;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= 4'h0;
            r_operand  <= 16'h0000;
            r_x        <= 8'h00;
            r_y        <= 8'h00;
            r_sp       <= 8'h00;
            r_bank     <= 8'h00;
            r_lo       <= 8'h00;
            r_ptr      <= 16'h0000;
            r_illegal  <= 1'b0;
`ifdef EA_SEQ_PAGE_PENALTY_EN
            r_pend_ea  <= '0;
`endif
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ea         <= '0;
            ea_valid   <= 1'b0;
            page_cross <= 1'b0;
            err        <= 1'b0;
        end else begin
            ea_valid   <= 1'b0;
            page_cross <= 1'b0;
            err        <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
                mem_req <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_mode    <= mode;
                            r_operand <= operand;
                            r_x       <= x;
                            r_y       <= y;
                            r_sp      <= sp;
                            r_bank    <= bank;
                            r_illegal <= (mode > 4'd10);
                            err       <= (mode > 4'd10);
                            r_state   <= S_CALC;
                            busy      <= 1'b1;
                        end
                    end
                    S_CALC: begin
                        if (r_illegal) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else if (w_indirect) begin
                            r_ptr    <= w_ptr;
                            mem_req  <= 1'b1;
                            mem_addr <= AW'(w_ptr);
                            r_state  <= S_RDLO;
                        end
                    end
                    S_RDLO: begin
                        if (mem_ack) begin
                            r_lo     <= mem_dat;
                            mem_addr <= AW'(w_ptr_next);
                            r_state  <= S_RDHI;
                        end
                    end
                    S_RDHI: begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                        end
                    end
`ifdef EA_SEQ_PAGE_PENALTY_EN
                    S_PEN: begin
                        ea         <= r_pend_ea;
                        ea_valid   <= 1'b1;
                        page_cross <= 1'b1;
                        r_state    <= S_DONE;
                    end
`endif
                    S_DONE: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                    end
                endcase

                if (w_finish) begin
`ifdef EA_SEQ_PAGE_PENALTY_EN
                    if (w_fin_cross) begin
                        r_pend_ea <= w_fin_ea;
                        r_state   <= S_PEN;
                    end else begin
                        ea       <= w_fin_ea;
                        ea_valid <= 1'b1;
                        r_state  <= S_DONE;
                    end
`else
                    ea         <= w_fin_ea;
                    ea_valid   <= 1'b1;
                    page_cross <= w_fin_cross;
                    r_state    <= S_DONE;
`endif
                end
            end
        end
    end

endmodule

`default_nettype wire
